// File: rtl/i2c_slave_ctrl_pkg.sv
// Shared definitions for the I2C slave controller: state encodings, default
// address and glitch-filter depth.
package i2c_slave_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_RX_BYTE  = 3'd3,
    ST_RX_ACK   = 3'd4,
    ST_TX_BYTE  = 3'd5,
    ST_TX_ACK   = 3'd6,
    ST_WAIT     = 3'd7
  } state_t;

  localparam logic [6:0] I2C_SLAVE_ADDR_DEFAULT = 7'h50;
  localparam int         I2C_SLAVE_FILT_DEPTH   = 3;

endpackage

// File: rtl/i2c_slave_sync.sv
// SCL/SDA 2-flop synchronizer; with I2C_SLAVE_GLITCH_FILTER_EN defined a
// 3-sample agreement filter follows it.
module i2c_slave_sync
  import i2c_slave_ctrl_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_scl,
  output logic o_sda
);

  logic [1:0] r_meta;
  logic [1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 2'b11;
      r_sync <= 2'b11;
    end else begin
      r_meta <= {i_sda, i_scl};
      r_sync <= r_meta;
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [I2C_SLAVE_FILT_DEPTH-2:0] r_hist_scl;
  logic [I2C_SLAVE_FILT_DEPTH-2:0] r_hist_sda;
  logic                            r_filt_scl;
  logic                            r_filt_sda;
  logic [I2C_SLAVE_FILT_DEPTH-1:0] w_win_scl;
  logic [I2C_SLAVE_FILT_DEPTH-1:0] w_win_sda;
  logic                            w_filt_scl;
  logic                            w_filt_sda;

  // The filtered level follows the line once the whole window agrees.
  assign w_win_scl  = {r_hist_scl, r_sync[0]};
  assign w_win_sda  = {r_hist_sda, r_sync[1]};
  assign w_filt_scl = ((&w_win_scl) | ~(|w_win_scl)) ? r_sync[0] : r_filt_scl;
  assign w_filt_sda = ((&w_win_sda) | ~(|w_win_sda)) ? r_sync[1] : r_filt_sda;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hist_scl <= '1;
      r_hist_sda <= '1;
      r_filt_scl <= 1'b1;
      r_filt_sda <= 1'b1;
    end else begin
      r_hist_scl <= {r_hist_scl[I2C_SLAVE_FILT_DEPTH-3:0], r_sync[0]};
      r_hist_sda <= {r_hist_sda[I2C_SLAVE_FILT_DEPTH-3:0], r_sync[1]};
      r_filt_scl <= w_filt_scl;
      r_filt_sda <= w_filt_sda;
    end
  end

  assign o_scl = w_filt_scl;
  assign o_sda = w_filt_sda;
`else
  assign o_scl = r_sync[0];
  assign o_sda = r_sync[1];
`endif

endmodule

// File: rtl/i2c_slave_ctrl.sv
// I2C slave: START/STOP detection, 7-bit address match, byte RX/TX with ACK.
// Optional input glitch filter via I2C_SLAVE_GLITCH_FILTER_EN.
//
// state    | meaning
// IDLE     | bus free, waiting for START
// ADDR     | shifting in address + R/W
// ADDR_ACK | waiting for / driving the address ACK slot
// RX_BYTE  | receiving a data byte
// RX_ACK   | driving ACK/NACK for a received byte
// TX_BYTE  | driving a data byte onto SDA
// TX_ACK   | sampling the master's ACK, loading the next byte on ACK
// WAIT     | not involved, SDA released until START/STOP
module i2c_slave_ctrl
  import i2c_slave_ctrl_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = I2C_SLAVE_ADDR_DEFAULT
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_sda_oe,
  input  logic       i_ack_en,
  input  logic [7:0] i_tx_data,
  output logic       o_tx_req,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_busy,
  output logic       o_addressed,
  output logic       o_rw,
  output logic       o_stop_det
);

  logic w_scl, w_sda;
  logic r_scl_d, r_sda_d;
  logic w_scl_rise, w_scl_fall, w_start, w_stop;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0] r_shift, w_shift_nxt;
  logic       r_phase, w_phase_nxt;
  logic       r_sda_oe, w_sda_oe_nxt;
  logic [7:0] r_rx_data, w_rx_data_nxt;
  logic       r_rx_valid, w_rx_valid_nxt;
  logic       r_tx_req, w_tx_req_nxt;
  logic       r_busy, w_busy_nxt;
  logic       r_addressed, w_addressed_nxt;
  logic       r_rw, w_rw_nxt;
  logic       r_stop_det, w_stop_det_nxt;

  i2c_slave_sync u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_scl   (i_scl),
    .i_sda   (i_sda),
    .o_scl   (w_scl),
    .o_sda   (w_sda)
  );

  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  assign w_start    = w_scl & r_scl_d & ~w_sda & r_sda_d;
  assign w_stop     = w_scl & r_scl_d & w_sda & ~r_sda_d;

  always_comb begin
    w_state_nxt     = r_state;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_shift_nxt     = r_shift;
    w_phase_nxt     = r_phase;
    w_sda_oe_nxt    = r_sda_oe;
    w_rx_data_nxt   = r_rx_data;
    w_rx_valid_nxt  = 1'b0;
    w_tx_req_nxt    = 1'b0;
    w_busy_nxt      = r_busy;
    w_addressed_nxt = r_addressed;
    w_rw_nxt        = r_rw;
    w_stop_det_nxt  = 1'b0;

    if (w_stop) begin
      w_state_nxt     = ST_IDLE;
      w_sda_oe_nxt    = 1'b0;
      w_busy_nxt      = 1'b0;
      w_addressed_nxt = 1'b0;
      w_stop_det_nxt  = 1'b1;
      w_phase_nxt     = 1'b0;
    end else if (w_start) begin
      w_state_nxt     = ST_ADDR;
      w_sda_oe_nxt    = 1'b0;
      w_busy_nxt      = 1'b1;
      w_addressed_nxt = 1'b0;
      w_bit_cnt_nxt   = 3'd0;
      w_phase_nxt     = 1'b0;
    end else begin
      case (r_state)
        ST_ADDR: begin
          if (w_scl_rise) begin
            w_shift_nxt   = {r_shift[6:0], w_sda};
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              if (r_shift[6:0] == SLAVE_ADDR) begin
                w_state_nxt     = ST_ADDR_ACK;
                w_addressed_nxt = 1'b1;
                w_rw_nxt        = w_sda;
                w_phase_nxt     = 1'b0;
              end else begin
                w_state_nxt = ST_WAIT;
              end
            end
          end
        end
        ST_ADDR_ACK: begin
          // r_phase: 0 = before the ACK slot, 1 = ACK being driven
          if (w_scl_rise && r_phase && r_rw) begin
            w_tx_req_nxt = 1'b1;
          end
          if (w_scl_fall) begin
            if (!r_phase) begin
              w_sda_oe_nxt = 1'b1;
              w_phase_nxt  = 1'b1;
            end else begin
              w_phase_nxt   = 1'b0;
              w_bit_cnt_nxt = 3'd0;
              if (r_rw) begin
                w_shift_nxt  = i_tx_data;
                w_sda_oe_nxt = ~i_tx_data[7];
                w_state_nxt  = ST_TX_BYTE;
              end else begin
                w_sda_oe_nxt = 1'b0;
                w_state_nxt  = ST_RX_BYTE;
              end
            end
          end
        end
        ST_RX_BYTE: begin
          if (w_scl_rise) begin
            w_shift_nxt   = {r_shift[6:0], w_sda};
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          end
          // A fall always follows a rise here, so a wrapped count means 8 bits.
          if (w_scl_fall && (r_bit_cnt == 3'd0)) begin
            w_rx_data_nxt  = r_shift;
            w_rx_valid_nxt = 1'b1;
            w_sda_oe_nxt   = i_ack_en;
            w_state_nxt    = ST_RX_ACK;
          end
        end
        ST_RX_ACK: begin
          if (w_scl_fall) begin
            w_sda_oe_nxt  = 1'b0;
            w_bit_cnt_nxt = 3'd0;
            w_state_nxt   = ST_RX_BYTE;
          end
        end
        ST_TX_BYTE: begin
          if (w_scl_rise) begin
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          end
          if (w_scl_fall) begin
            if (r_bit_cnt == 3'd0) begin
              w_sda_oe_nxt = 1'b0;
              w_phase_nxt  = 1'b0;
              w_state_nxt  = ST_TX_ACK;
            end else begin
              w_shift_nxt  = {r_shift[6:0], 1'b0};
              w_sda_oe_nxt = ~r_shift[6];
            end
          end
        end
        ST_TX_ACK: begin
          if (w_scl_rise) begin
            if (w_sda) begin
              w_state_nxt = ST_WAIT;
            end else begin
              w_tx_req_nxt = 1'b1;
              w_phase_nxt  = 1'b1;
            end
          end
          if (w_scl_fall && r_phase) begin
            w_phase_nxt   = 1'b0;
            w_bit_cnt_nxt = 3'd0;
            w_shift_nxt   = i_tx_data;
            w_sda_oe_nxt  = ~i_tx_data[7];
            w_state_nxt   = ST_TX_BYTE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_scl_d     <= 1'b1;
      r_sda_d     <= 1'b1;
      r_state     <= ST_IDLE;
      r_bit_cnt   <= 3'd0;
      r_shift     <= 8'h00;
      r_phase     <= 1'b0;
      r_sda_oe    <= 1'b0;
      r_rx_data   <= 8'h00;
      r_rx_valid  <= 1'b0;
      r_tx_req    <= 1'b0;
      r_busy      <= 1'b0;
      r_addressed <= 1'b0;
      r_rw        <= 1'b0;
      r_stop_det  <= 1'b0;
    end else begin
      r_scl_d     <= w_scl;
      r_sda_d     <= w_sda;
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_phase     <= w_phase_nxt;
      r_sda_oe    <= w_sda_oe_nxt;
      r_rx_data   <= w_rx_data_nxt;
      r_rx_valid  <= w_rx_valid_nxt;
      r_tx_req    <= w_tx_req_nxt;
      r_busy      <= w_busy_nxt;
      r_addressed <= w_addressed_nxt;
      r_rw        <= w_rw_nxt;
      r_stop_det  <= w_stop_det_nxt;
    end
  end

  assign o_sda_oe    = r_sda_oe;
  assign o_rx_data   = r_rx_data;
  assign o_rx_valid  = r_rx_valid;
  assign o_tx_req    = r_tx_req;
  assign o_busy      = r_busy;
  assign o_addressed = r_addressed;
  assign o_rw        = r_rw;
  assign o_stop_det  = r_stop_det;

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Self-checking bench for i2c_slave_ctrl: bench-side I2C master plus
// scoreboard queues for received and transmitted bytes.
`timescale 1ns/1ps
module tb_i2c_slave_ctrl;

  logic       clk;
  logic       rst_n;
  logic       r_m_scl;
  logic       r_m_sda;
  logic       ack_en;
  logic [7:0] tx_data;
  wire        w_sda_line;
  logic       sda_oe, tx_req, rx_valid, busy, addressed, rw, stop_det;
  logic [7:0] rx_data;

  int n_checks = 0;
  int n_fails  = 0;

  logic [7:0] q_exp_rx[$];
  logic [7:0] q_exp_tx[$];
  logic [7:0] q_rx_seen[$];
  int rx_rd = 0;
  int tx_req_cnt = 0;
  int stop_cnt = 0;
  int oe_cnt = 0;
  int overlap_cnt = 0;

  assign w_sda_line = r_m_sda & ~sda_oe;

  i2c_slave_ctrl dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_scl       (r_m_scl),
    .i_sda       (w_sda_line),
    .o_sda_oe    (sda_oe),
    .i_ack_en    (ack_en),
    .i_tx_data   (tx_data),
    .o_tx_req    (tx_req),
    .o_rx_data   (rx_data),
    .o_rx_valid  (rx_valid),
    .o_busy      (busy),
    .o_addressed (addressed),
    .o_rw        (rw),
    .o_stop_det  (stop_det)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) q_rx_seen.push_back(rx_data);
    if (tx_req) tx_req_cnt++;
    if (stop_det) stop_cnt++;
    if (sda_oe) oe_cnt++;
    if (rx_valid && stop_det) overlap_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic m_start();
    r_m_sda = 1'b0;
    wait_clk(10);
    r_m_scl = 1'b0;
    wait_clk(6);
  endtask

  task automatic m_rep_start();
    r_m_sda = 1'b1;
    wait_clk(6);
    r_m_scl = 1'b1;
    wait_clk(5);
    r_m_sda = 1'b0;
    wait_clk(5);
    r_m_scl = 1'b0;
    wait_clk(6);
  endtask

  task automatic m_stop();
    r_m_sda = 1'b0;
    wait_clk(6);
    r_m_scl = 1'b1;
    wait_clk(10);
    r_m_sda = 1'b1;
    wait_clk(10);
  endtask

  task automatic m_bit(input logic b, output logic s);
    r_m_sda = b;
    wait_clk(6);
    r_m_scl = 1'b1;
    wait_clk(5);
    #1 s = w_sda_line;
    wait_clk(5);
    r_m_scl = 1'b0;
    wait_clk(6);
  endtask

  task automatic m_write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) m_bit(d[i], s);
    m_bit(1'b1, ack);
  endtask

  task automatic m_read_byte(output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      m_bit(1'b1, s);
      d[i] = s;
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if (sda_oe !== 1'b0 || busy !== 1'b0 || addressed !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_ctrl: oe/busy/addr=%b%b%b want 000", sda_oe, busy, addressed);
    end
    n_checks++;
    if (rx_data !== 8'h00 || rw !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_data: rx_data=%h rw=%b want 00 0", rx_data, rw);
    end
    n_checks++;
    if (rx_valid !== 1'b0 || tx_req !== 1'b0 || stop_det !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_pulses: rxv/txr/stop=%b%b%b want 000", rx_valid, tx_req, stop_det);
    end
  endtask

  task automatic test_write();
    logic ack;
    int st0;
    logic [7:0] exp;
    st0 = stop_cnt;
    m_start();
    n_checks++;
    if (busy !== 1'b1) begin n_fails++; $display("FAIL write_busy: got %b want 1", busy); end
    m_write_byte(8'hA0, ack);
    n_checks++;
    if (ack !== 1'b0) begin n_fails++; $display("FAIL write_addr_ack: line=%b want 0", ack); end
    n_checks++;
    if (addressed !== 1'b1 || rw !== 1'b0) begin
      n_fails++;
      $display("FAIL write_addressed: addressed=%b rw=%b want 1 0", addressed, rw);
    end
    q_exp_rx.push_back(8'h3C);
    m_write_byte(8'h3C, ack);
    n_checks++;
    if (ack !== 1'b0) begin n_fails++; $display("FAIL write_data_ack: line=%b want 0", ack); end
    exp = q_exp_rx.pop_front();
    n_checks++;
    if (q_rx_seen.size() != rx_rd + 1) begin
      n_fails++;
      $display("FAIL write_rx_count: got %0d pulses want 1", q_rx_seen.size() - rx_rd);
      rx_rd = q_rx_seen.size();
    end else if (q_rx_seen[rx_rd] !== exp) begin
      n_fails++;
      $display("FAIL write_rx_data: got %h want %h", q_rx_seen[rx_rd], exp);
      rx_rd++;
    end else rx_rd++;
    m_stop();
    n_checks++;
    if (busy !== 1'b0 || addressed !== 1'b0 || stop_cnt - st0 != 1) begin
      n_fails++;
      $display("FAIL write_stop: busy=%b addressed=%b stop_pulses=%0d want 0 0 1",
               busy, addressed, stop_cnt - st0);
    end
  endtask

  task automatic test_mismatch();
    logic ack;
    int oe0, st0, rx0;
    oe0 = oe_cnt; st0 = stop_cnt; rx0 = q_rx_seen.size();
    m_start();
    m_write_byte({7'h51, 1'b0}, ack);
    n_checks++;
    if (ack !== 1'b1) begin n_fails++; $display("FAIL mismatch_ack: line=%b want 1", ack); end
    m_write_byte(8'h00, ack);
    n_checks++;
    if (ack !== 1'b1 || addressed !== 1'b0 || busy !== 1'b1) begin
      n_fails++;
      $display("FAIL mismatch_wait: ack=%b addressed=%b busy=%b want 1 0 1", ack, addressed, busy);
    end
    m_stop();
    n_checks++;
    if (oe_cnt != oe0 || stop_cnt - st0 != 1 || q_rx_seen.size() != rx0) begin
      n_fails++;
      $display("FAIL mismatch_end: oe_cycles=%0d stop=%0d rx=%0d want 0 1 0",
               oe_cnt - oe0, stop_cnt - st0, q_rx_seen.size() - rx0);
    end
    rx_rd = q_rx_seen.size();
  endtask

  task automatic test_read();
    logic ack, s;
    logic [7:0] d, exp;
    int tq0;
    tq0 = tx_req_cnt;
    tx_data = 8'hA5;
    q_exp_tx.push_back(8'hA5);
    m_start();
    m_write_byte(8'hA1, ack);
    n_checks++;
    if (ack !== 1'b0 || rw !== 1'b1 || tx_req_cnt - tq0 != 1) begin
      n_fails++;
      $display("FAIL read_addr: ack=%b rw=%b tx_req=%0d want 0 1 1", ack, rw, tx_req_cnt - tq0);
    end
    m_read_byte(d);
    exp = q_exp_tx.pop_front();
    n_checks++;
    if (d !== exp) begin n_fails++; $display("FAIL read_byte0: got %h want %h", d, exp); end
    tx_data = 8'h0F;
    q_exp_tx.push_back(8'h0F);
    m_bit(1'b0, s);
    n_checks++;
    if (tx_req_cnt - tq0 != 2) begin
      n_fails++;
      $display("FAIL read_txreq_ack: got %0d want 2", tx_req_cnt - tq0);
    end
    m_read_byte(d);
    exp = q_exp_tx.pop_front();
    n_checks++;
    if (d !== exp) begin n_fails++; $display("FAIL read_byte1: got %h want %h", d, exp); end
    m_bit(1'b1, s);
    m_read_byte(d);
    n_checks++;
    if (d !== 8'hFF || tx_req_cnt - tq0 != 2 || busy !== 1'b1) begin
      n_fails++;
      $display("FAIL read_after_nack: sda=%h tx_req=%0d busy=%b want ff 2 1",
               d, tx_req_cnt - tq0, busy);
    end
    m_stop();
    n_checks++;
    if (busy !== 1'b0) begin n_fails++; $display("FAIL read_stop: busy=%b want 0", busy); end
  endtask

  task automatic test_nack();
    logic ack;
    logic [7:0] exp;
    ack_en = 1'b0;
    m_start();
    m_write_byte(8'hA0, ack);
    n_checks++;
    if (ack !== 1'b0) begin n_fails++; $display("FAIL nack_addr_ack: line=%b want 0", ack); end
    q_exp_rx.push_back(8'h77);
    m_write_byte(8'h77, ack);
    n_checks++;
    if (ack !== 1'b1) begin n_fails++; $display("FAIL nack_data_slot: line=%b want 1", ack); end
    exp = q_exp_rx.pop_front();
    n_checks++;
    if (q_rx_seen.size() != rx_rd + 1) begin
      n_fails++;
      $display("FAIL nack_rx_count: got %0d pulses want 1", q_rx_seen.size() - rx_rd);
      rx_rd = q_rx_seen.size();
    end else if (q_rx_seen[rx_rd] !== exp || rx_data !== exp) begin
      n_fails++;
      $display("FAIL nack_rx_data: got %h want %h", q_rx_seen[rx_rd], exp);
      rx_rd++;
    end else rx_rd++;
    m_stop();
    ack_en = 1'b1;
  endtask

  task automatic test_rep_start();
    logic ack, s;
    logic [7:0] d, exp;
    int rx0;
    m_start();
    m_write_byte(8'hA0, ack);
    rx0 = q_rx_seen.size();
    m_bit(1'b1, s); m_bit(1'b0, s); m_bit(1'b1, s); m_bit(1'b0, s);
    m_rep_start();
    n_checks++;
    if (addressed !== 1'b0 || busy !== 1'b1) begin
      n_fails++;
      $display("FAIL rs_restart: addressed=%b busy=%b want 0 1", addressed, busy);
    end
    tx_data = 8'hC3;
    q_exp_tx.push_back(8'hC3);
    m_write_byte(8'hA1, ack);
    n_checks++;
    if (ack !== 1'b0 || rw !== 1'b1 || addressed !== 1'b1 || q_rx_seen.size() != rx0) begin
      n_fails++;
      $display("FAIL rs_addr: ack=%b rw=%b addressed=%b rx=%0d want 0 1 1 0",
               ack, rw, addressed, q_rx_seen.size() - rx0);
    end
    m_read_byte(d);
    exp = q_exp_tx.pop_front();
    n_checks++;
    if (d !== exp) begin n_fails++; $display("FAIL rs_read: got %h want %h", d, exp); end
    m_bit(1'b1, s);
    m_stop();
  endtask

  task automatic test_async_reset();
    logic s;
    bit seen;
    logic [7:0] a;
    a = 8'hA0;
    seen = 0;
    m_start();
    for (int i = 7; i >= 0; i--) m_bit(a[i], s);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (sda_oe === 1'b1) seen = 1;
    end
    n_checks++;
    if (!seen) begin
      n_fails++;
      $display("FAIL arst_ack_wait: sda_oe=%b want 1 within 20 cycles", sda_oe);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (sda_oe !== 1'b0 || busy !== 1'b0 || addressed !== 1'b0) begin
      n_fails++;
      $display("FAIL arst_outputs: oe/busy/addr=%b%b%b want 000", sda_oe, busy, addressed);
    end
    r_m_scl = 1'b1;
    r_m_sda = 1'b1;
    wait_clk(3);
    @(negedge clk);
    rst_n = 1'b1;
    wait_clk(4);
  endtask

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  task automatic test_glitch();
    int st0;
    st0 = stop_cnt;
    @(negedge clk);
    r_m_sda = 1'b0;
    wait_clk(2);
    r_m_sda = 1'b1;
    wait_clk(12);
    n_checks++;
    if (busy !== 1'b0 || stop_cnt != st0) begin
      n_fails++;
      $display("FAIL glitch: busy=%b stop=%0d want 0 0", busy, stop_cnt - st0);
    end
  endtask
`endif

  initial begin
    rst_n   = 1'b0;
    r_m_scl = 1'b1;
    r_m_sda = 1'b1;
    ack_en  = 1'b1;
    tx_data = 8'h00;
    wait_clk(5);
    #1 test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    wait_clk(5);
    test_write();
    test_mismatch();
    test_read();
    test_nack();
    test_rep_start();
    test_async_reset();
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    test_glitch();
`endif
    n_checks++;
    if (overlap_cnt != 0) begin
      n_fails++;
      $display("FAIL rxvalid_stop_overlap: got %0d cycles want 0", overlap_cnt);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
